// File: rtl/video_scroll.sv
// rtl/video_scroll.sv - scroll/address register file with t/v/fine_x/w and the buffered CPU VRAM data port
module video_scroll (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [7:0]  I_data,
  input  logic [7:0]  I_reg_wrrise,
  input  logic [7:0]  I_reg_rdfall,
  input  logic        I_inc_x,
  input  logic        I_inc_y,
  input  logic        I_copy_x,
  input  logic        I_copy_y,
  output logic [14:0] O_v,
  output logic [14:0] O_t,
  output logic [2:0]  O_fine_x,
  output logic        O_w,
  output logic [7:0]  O_rdbuf,
  output logic        O_vram_req,
  output logic        O_vram_we,
  output logic [13:0] O_vram_addr,
  output logic [7:0]  O_vram_wdata,
  input  logic        I_vram_ack,
  input  logic [7:0]  I_vram_rdata,
  output logic        O_busy
);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_e;

  state_e      state_q, state_d;
  logic [14:0] v_q, v_d, t_q, t_d;
  logic [2:0]  fine_x_q, fine_x_d;
  logic        w_q, w_d, inc32_q, inc32_d;
  logic [7:0]  rdbuf_q, rdbuf_d, wdata_q, wdata_d;
  logic [13:0] addr_q, addr_d;

  logic ctrl_wr, stat_rd, scrl_wr, addr_wr, data_wr, data_rd, ack_inc;
  logic [14:0] step, v_inc_x, v_inc_y;
  logic unused_strobes;

  assign ctrl_wr = I_reg_wrrise[0];
  assign stat_rd = I_reg_rdfall[2];
  assign scrl_wr = I_reg_wrrise[5];
  assign addr_wr = I_reg_wrrise[6];
  assign data_wr = I_reg_wrrise[7];
  assign data_rd = I_reg_rdfall[7];
  assign unused_strobes = ^{I_reg_wrrise[4:1], I_reg_rdfall[6:3], I_reg_rdfall[1:0]};

  assign step = inc32_q ? 15'd32 : 15'd1;

  // Coarse X wraps into the horizontal nametable select bit
  always_comb begin
    v_inc_x = v_q;
    if (v_q[4:0] == 5'd31) begin
      v_inc_x[4:0] = 5'd0;
      v_inc_x[10] = ~v_q[10];
    end else begin
      v_inc_x[4:0] = v_q[4:0] + 5'd1;
    end
  end

  // Row 29 is the last visible tile row; rows 30/31 wrap without a nametable switch
  always_comb begin
    v_inc_y = v_q;
    if (v_q[14:12] != 3'd7) begin
      v_inc_y[14:12] = v_q[14:12] + 3'd1;
    end else begin
      v_inc_y[14:12] = 3'd0;
      if (v_q[9:5] == 5'd29) begin
        v_inc_y[9:5] = 5'd0;
        v_inc_y[11] = ~v_q[11];
      end else if (v_q[9:5] == 5'd31) begin
        v_inc_y[9:5] = 5'd0;
      end else begin
        v_inc_y[9:5] = v_q[9:5] + 5'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    fine_x_d = fine_x_q;
    w_d      = w_q;
    inc32_d  = inc32_q;
    rdbuf_d  = rdbuf_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_inc  = 1'b0;

    if (ctrl_wr) begin
      t_d[11:10] = I_data[1:0];
      inc32_d    = I_data[2];
    end
    if (stat_rd) w_d = 1'b0;
    if (scrl_wr) begin
      if (!w_q) begin
        t_d[4:0] = I_data[7:3];
        fine_x_d = I_data[2:0];
        w_d      = 1'b1;
      end else begin
        t_d[14:12] = I_data[2:0];
        t_d[9:5]   = I_data[7:3];
        w_d        = 1'b0;
      end
    end
    if (addr_wr) begin
      if (!w_q) begin
        t_d[13:8] = I_data[5:0];
        t_d[14]   = 1'b0;
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = I_data;
        w_d      = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (data_wr) begin
          addr_d  = v_q[13:0];
          wdata_d = I_data;
          state_d = WR_WAIT;
        end else if (data_rd) begin
          addr_d  = v_q[13:0];
          state_d = RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (I_vram_ack) begin
          ack_inc = 1'b1;
          if (state_q == RD_WAIT) rdbuf_d = I_vram_rdata;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    v_d = v_q;
    if (addr_wr && w_q)  v_d = {t_q[14:8], I_data};
    else if (ack_inc)    v_d = v_q + step;
    else if (I_copy_y)   v_d = {t_q[14:11], v_q[10], t_q[9:5], v_q[4:0]};
    else if (I_copy_x)   v_d = {v_q[14:11], t_q[10], v_q[9:5], t_q[4:0]};
    else if (I_inc_y)    v_d = v_inc_y;
    else if (I_inc_x)    v_d = v_inc_x;
  end

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= IDLE;
      v_q      <= '0;
      t_q      <= '0;
      fine_x_q <= '0;
      w_q      <= 1'b0;
      inc32_q  <= 1'b0;
      rdbuf_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      t_q      <= t_d;
      fine_x_q <= fine_x_d;
      w_q      <= w_d;
      inc32_q  <= inc32_d;
      rdbuf_q  <= rdbuf_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign O_v          = v_q;
  assign O_t          = t_q;
  assign O_fine_x     = fine_x_q;
  assign O_w          = w_q;
  assign O_rdbuf      = rdbuf_q;
  assign O_vram_req   = (state_q != IDLE);
  assign O_vram_we    = (state_q == WR_WAIT);
  assign O_busy       = (state_q != IDLE);
  assign O_vram_addr  = addr_q;
  assign O_vram_wdata = wdata_q;

endmodule

// File: tb/tb_video_scroll.sv
// tb/tb_video_scroll.sv - register-sequence vectors, VRAM access scoreboard and render-op checks for video_scroll
module tb_video_scroll;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data, wrrise, rdfall;
  logic        inc_x, inc_y, copy_x, copy_y;
  logic [14:0] v, t;
  logic [2:0]  fine_x;
  logic        w, req, we, busy, ack;
  logic [7:0]  rdbuf, wdata, rdata;
  logic [13:0] addr;

  int checks = 0;
  int errors = 0;

  localparam int OP_CTRL = 0, OP_STAT = 1, OP_SCRL = 2, OP_ADDR = 3;

  typedef struct {
    int          op;
    logic [7:0]  d;
    logic [14:0] et;
    logic [14:0] ev;
    logic [2:0]  efx;
    logic        ew;
  } vec_t;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } req_t;

  vec_t vecs[13];
  req_t exp_q[$];

  always #5 clk = ~clk;

  video_scroll dut (
    .I_clock(clk), .I_reset(rst), .I_data(data),
    .I_reg_wrrise(wrrise), .I_reg_rdfall(rdfall),
    .I_inc_x(inc_x), .I_inc_y(inc_y), .I_copy_x(copy_x), .I_copy_y(copy_y),
    .O_v(v), .O_t(t), .O_fine_x(fine_x), .O_w(w), .O_rdbuf(rdbuf),
    .O_vram_req(req), .O_vram_we(we), .O_vram_addr(addr), .O_vram_wdata(wdata),
    .I_vram_ack(ack), .I_vram_rdata(rdata), .O_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic reg_op(input int op, input logic [7:0] d);
    @(negedge clk);
    data = d;
    case (op)
      OP_CTRL: wrrise[0] = 1'b1;
      OP_STAT: rdfall[2] = 1'b1;
      OP_SCRL: wrrise[5] = 1'b1;
      default: wrrise[6] = 1'b1;
    endcase
    @(negedge clk);
    wrrise = '0;
    rdfall = '0;
  endtask

  task automatic render(input logic ix, input logic iy, input logic cx, input logic cy);
    @(negedge clk);
    {inc_x, inc_y, copy_x, copy_y} = {ix, iy, cx, cy};
    @(negedge clk);
    {inc_x, inc_y, copy_x, copy_y} = 4'b0;
  endtask

  task automatic data_access(input logic is_wr, input logic [13:0] exp_addr, input logic [7:0] wd,
                             input int dly, input logic [7:0] rd, input logic [7:0] old_rdbuf,
                             input logic busy_strobe);
    req_t e;
    int n;
    exp_q.push_back('{is_wr, exp_addr, wd});
    @(negedge clk);
    data = wd;
    if (is_wr) wrrise[7] = 1'b1;
    else       rdfall[7] = 1'b1;
    @(negedge clk);
    wrrise = '0;
    rdfall = '0;
    n = 0;
    while (!req && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_start", {31'd0, req}, 32'd1);
    e = exp_q.pop_front();
    if (!req) return;
    chk("req_we", {31'd0, we}, {31'd0, e.we});
    chk("req_addr", {18'd0, addr}, {18'd0, e.addr});
    if (e.we) chk("req_wdata", {24'd0, wdata}, {24'd0, e.wdata});
    for (int i = 0; i < dly; i++) begin
      chk("req_held", {31'd0, req}, 32'd1);
      chk("addr_held", {18'd0, addr}, {18'd0, e.addr});
      if (e.we) chk("wdata_held", {24'd0, wdata}, {24'd0, e.wdata});
      if (!e.we && i == 0) chk("rdbuf_before_ack", {24'd0, rdbuf}, {24'd0, old_rdbuf});
      if (busy_strobe && i == 0) begin
        if (is_wr) wrrise[7] = 1'b1;
        else       rdfall[7] = 1'b1;
      end
      if (i == 1) begin
        wrrise = '0;
        rdfall = '0;
      end
      if (i == dly - 1) begin
        ack   = 1'b1;
        rdata = rd;
      end
      @(negedge clk);
    end
    ack    = 1'b0;
    wrrise = '0;
    rdfall = '0;
    chk("req_drop", {31'd0, req}, 32'd0);
    chk("busy_drop", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_SCRL, 8'h7D, 15'h000F, 15'h0000, 3'd5, 1'b1};
    vecs[1]  = '{OP_SCRL, 8'h5E, 15'h616F, 15'h0000, 3'd5, 1'b0};
    vecs[2]  = '{OP_SCRL, 8'h7D, 15'h616F, 15'h0000, 3'd5, 1'b1};
    vecs[3]  = '{OP_STAT, 8'h00, 15'h616F, 15'h0000, 3'd5, 1'b0};
    vecs[4]  = '{OP_SCRL, 8'h08, 15'h6161, 15'h0000, 3'd0, 1'b1};
    vecs[5]  = '{OP_CTRL, 8'h03, 15'h6D61, 15'h0000, 3'd0, 1'b1};
    vecs[6]  = '{OP_STAT, 8'h00, 15'h6D61, 15'h0000, 3'd0, 1'b0};
    vecs[7]  = '{OP_ADDR, 8'h3F, 15'h3F61, 15'h0000, 3'd0, 1'b1};
    vecs[8]  = '{OP_ADDR, 8'h10, 15'h3F10, 15'h3F10, 3'd0, 1'b0};
    vecs[9]  = '{OP_ADDR, 8'hFF, 15'h3F10, 15'h3F10, 3'd0, 1'b1};
    vecs[10] = '{OP_ADDR, 8'h42, 15'h3F42, 15'h3F42, 3'd0, 1'b0};
    vecs[11] = '{OP_ADDR, 8'h20, 15'h2042, 15'h3F42, 3'd0, 1'b1};
    vecs[12] = '{OP_ADDR, 8'h00, 15'h2000, 15'h2000, 3'd0, 1'b0};

    rst = 1'b1;
    data = '0; wrrise = '0; rdfall = '0;
    {inc_x, inc_y, copy_x, copy_y} = 4'b0;
    ack = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_v", {17'd0, v}, 32'd0);
    chk("rst_t", {17'd0, t}, 32'd0);
    chk("rst_fx_w", {28'd0, fine_x, w}, 32'd0);
    chk("rst_port", {14'd0, req, we, busy, rdbuf, addr}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      reg_op(vecs[i].op, vecs[i].d);
      chk($sformatf("vec%0d_t", i), {17'd0, t}, {17'd0, vecs[i].et});
      chk($sformatf("vec%0d_v", i), {17'd0, v}, {17'd0, vecs[i].ev});
      chk($sformatf("vec%0d_fx", i), {29'd0, fine_x}, {29'd0, vecs[i].efx});
      chk($sformatf("vec%0d_w", i), {31'd0, w}, {31'd0, vecs[i].ew});
    end

    data_access(1'b1, 14'h2000, 8'h5A, 3, 8'h00, 8'h00, 1'b0);
    chk("wr1_v", {17'd0, v}, 32'h2001);
    reg_op(OP_CTRL, 8'h04);
    data_access(1'b1, 14'h2001, 8'h77, 1, 8'h00, 8'h00, 1'b0);
    chk("wr32_v", {17'd0, v}, 32'h2021);
    reg_op(OP_CTRL, 8'h00);
    reg_op(OP_ADDR, 8'h23);
    reg_op(OP_ADDR, 8'hFF);
    chk("rd_setup_v", {17'd0, v}, 32'h23FF);
    data_access(1'b0, 14'h23FF, 8'h00, 1, 8'h11, 8'h00, 1'b0);
    chk("rd1_rdbuf", {24'd0, rdbuf}, 32'h11);
    chk("rd1_v", {17'd0, v}, 32'h2400);
    data_access(1'b0, 14'h2400, 8'h00, 3, 8'hAB, 8'h11, 1'b1);
    chk("rd2_rdbuf", {24'd0, rdbuf}, 32'hAB);
    chk("rd2_v", {17'd0, v}, 32'h2401);
    @(negedge clk);
    chk("busy_strobe_ignored", {31'd0, req}, 32'd0);
    chk("busy_strobe_v", {17'd0, v}, 32'h2401);

    reg_op(OP_ADDR, 8'h00);
    reg_op(OP_ADDR, 8'h1F);
    render(1'b1, 1'b0, 1'b0, 1'b0);
    chk("incx_wrap", {17'd0, v}, 32'h0400);
    render(1'b1, 1'b0, 1'b0, 1'b0);
    chk("incx_plain", {17'd0, v}, 32'h0401);
    reg_op(OP_SCRL, 8'h00);
    reg_op(OP_SCRL, 8'hEF);
    chk("scrl_t_y29", {17'd0, t}, 32'h73A0);
    render(1'b0, 1'b0, 1'b0, 1'b1);
    chk("copy_y29", {17'd0, v}, 32'h77A1);
    render(1'b0, 1'b1, 1'b0, 1'b0);
    chk("incy_row29", {17'd0, v}, 32'h0C01);
    reg_op(OP_SCRL, 8'h00);
    reg_op(OP_SCRL, 8'hFF);
    render(1'b0, 1'b0, 1'b0, 1'b1);
    chk("copy_y31", {17'd0, v}, 32'h77E1);
    render(1'b0, 1'b1, 1'b0, 1'b0);
    chk("incy_row31", {17'd0, v}, 32'h0401);
    render(1'b0, 1'b1, 1'b0, 1'b0);
    chk("incy_fine", {17'd0, v}, 32'h1401);
    render(1'b1, 1'b1, 1'b0, 1'b0);
    chk("incxy_same_cycle", {17'd0, v}, 32'h2401);
    render(1'b1, 1'b0, 1'b1, 1'b0);
    chk("copy_x_over_incx", {17'd0, v}, 32'h2000);

    exp_q.push_back('{1'b1, 14'h2000, 8'h99});
    @(negedge clk);
    data = 8'h99;
    wrrise[7] = 1'b1;
    @(negedge clk);
    wrrise = '0;
    begin
      req_t e;
      e = exp_q.pop_front();
      chk("rstacc_req", {31'd0, req}, 32'd1);
      chk("rstacc_addr", {18'd0, addr}, {18'd0, e.addr});
      chk("rstacc_wdata", {24'd0, wdata}, {24'd0, e.wdata});
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_v_t", {2'd0, v, t}, 32'd0);
    chk("midrst_fx_w_rdbuf", {20'd0, fine_x, w, rdbuf}, 32'd0);
    chk("midrst_port", {6'd0, req, we, busy, wdata, addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack = 1'b1;
    rdata = 8'h55;
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_req", {31'd0, req}, 32'd0);
    chk("late_ack_v", {17'd0, v}, 32'd0);
    chk("late_ack_rdbuf", {24'd0, rdbuf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
